// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory access stage behind the multicycle control unit. It turns a
//   one-cycle memory_read / memory_write command into a held bus_req/bus_ack
//   transaction. Read data is captured into a memory data register (rdata).
//   It also reports busy and error status to the stall and trap logic.
//   Only one access can be outstanding. Fetches and data accesses share the
//   same port.
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   memory_read, memory_write, lorD  command and address select from control
//   pc, alu_out, write_data          datapath fetch addr, data addr, store data
//   bus_req/we/addr/wdata            outgoing request, held until ack/timeout
//   bus_ack, bus_rdata               slave completion and read data
//   rdata, rdata_valid               memory data register, 1-cycle valid pulse
//   busy, err, err_sticky            access outstanding, error pulse, sticky err
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memory_read,
    input  logic                  memory_write,
    input  logic                  lorD,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] alu_out,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  busy,
    output logic                  err,
    output logic                  err_sticky
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  sticky_q, sticky_d;

    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  timeout_hit;

    assign cmd_addr = lorD ? alu_out : pc;
    // The counter holds the number of ack-less cycles already spent. Firing at
    // TIMEOUT_CYCLES-1 gives exactly TIMEOUT_CYCLES cycles of bus_req.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (memory_read && memory_write) begin
                    err_d = 1'b1;
                end else if (memory_read || memory_write) begin
                    if (cmd_addr[1:0] != 2'b00) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        addr_d  = cmd_addr;
                        we_d    = memory_write;
                        wdata_d = write_data;
                        cnt_d   = '0;
                    end
                end
            end
            ACCESS: begin
                // New commands are ignored here; upstream stalls on busy.
                if (bus_ack) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = bus_rdata;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        sticky_d = sticky_q | err_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus_req     = (state_q == ACCESS);
    assign busy        = bus_req;
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_wdata   = wdata_q;
    assign rdata       = rdata_q;
    // we_q still describes the access that just finished while in DONE.
    assign rdata_valid = (state_q == DONE) && !we_q;
    assign err         = err_q;
    assign err_sticky  = sticky_q;

endmodule
